// File: rtl/instr_fetch_unit_pkg.sv
// fetch_pkg: shared definitions for the instruction-fetch stage.
//   - fetch_state_e  : FSM state encoding (S_IDLE/S_FETCH/S_ISSUE, 2 bits)
//   - field positions of OPCODE/DEST/SRC1/SRC2_IMM inside the 32-bit word
//   - INSTR_W        : instruction width
//   - DEFAULT_PC_STEP: default byte increment per sequential instruction
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2
    } fetch_state_e;

    localparam int unsigned INSTR_W  = 32;

    localparam int unsigned OP_MSB   = 31;
    localparam int unsigned OP_LSB   = 24;
    localparam int unsigned DEST_MSB = 23;
    localparam int unsigned DEST_LSB = 16;
    localparam int unsigned SRC1_MSB = 15;
    localparam int unsigned SRC1_LSB = 8;
    localparam int unsigned SRC2_MSB = 7;
    localparam int unsigned SRC2_LSB = 0;

    localparam logic [31:0] DEFAULT_PC_STEP = 32'd4;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction-memory bus plus issue bus of the fetch stage.
//   IMEM_READ/IMEM_ADDRESS      : read request from the fetch unit
//   IMEM_READDATA/IMEM_BUSYWAIT : memory response / not-ready
//   STALL                       : downstream not ready
//   INSTR_VALID/PC_OUT/fields   : issued instruction towards the decoder
// modport master = fetch unit side, slave = memory + downstream side.
interface instr_fetch_unit_if;

    logic        IMEM_READ;
    logic [31:0] IMEM_ADDRESS;
    logic [31:0] IMEM_READDATA;
    logic        IMEM_BUSYWAIT;
    logic        STALL;
    logic        INSTR_VALID;
    logic [31:0] PC_OUT;
    logic [7:0]  OPCODE;
    logic [7:0]  DEST;
    logic [7:0]  SRC1;
    logic [7:0]  SRC2_IMM;

    modport master (
        output IMEM_READ, IMEM_ADDRESS, INSTR_VALID, PC_OUT,
               OPCODE, DEST, SRC1, SRC2_IMM,
        input  IMEM_READDATA, IMEM_BUSYWAIT, STALL
    );

    modport slave (
        input  IMEM_READ, IMEM_ADDRESS, INSTR_VALID, PC_OUT,
               OPCODE, DEST, SRC1, SRC2_IMM,
        output IMEM_READDATA, IMEM_BUSYWAIT, STALL
    );

endinterface

// File: rtl/instr_fetch_unit_pc_next_calc.sv
// pc_next_calc: combinational next-PC computation.
//   pc_i            : current PC
//   pc_seq_o        : pc_i + PC_STEP (wraps modulo 2^32)
//   branch_offset_i : signed word offset   (only with FETCH_BRANCH_EN)
//   pc_branch_o     : pc_i + (offset << 2) (only with FETCH_BRANCH_EN)
// Optional feature macro: FETCH_BRANCH_EN
module pc_next_calc
    import fetch_pkg::*;
#(
    parameter logic [31:0] PC_STEP = DEFAULT_PC_STEP
) (
`ifdef FETCH_BRANCH_EN
    input  logic [7:0]  branch_offset_i,
    output logic [31:0] pc_branch_o,
`endif
    input  logic [31:0] pc_i,
    output logic [31:0] pc_seq_o
);

    assign pc_seq_o = pc_i + PC_STEP;

`ifdef FETCH_BRANCH_EN
    // Sign-extend the word offset and convert to bytes.
    assign pc_branch_o = pc_i + {{22{branch_offset_i[7]}}, branch_offset_i, 2'b00};
`endif

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC register, fetch FSM and instruction register.
//   CLK, RESET     : clock, asynchronous active-high reset
//   bus (master)   : IMEM read handshake and issued-instruction outputs
//   BRANCH_TAKEN   : take relative branch at consume edge (FETCH_BRANCH_EN)
//   BRANCH_OFFSET  : signed word offset                   (FETCH_BRANCH_EN)
// Optional feature macro: FETCH_BRANCH_EN
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic CLK,
    input  logic RESET,
`ifdef FETCH_BRANCH_EN
    input  logic       BRANCH_TAKEN,
    input  logic [7:0] BRANCH_OFFSET,
`endif
    instr_fetch_unit_if.master bus
);

    fetch_state_e         state_q, state_d;
    logic [31:0]          pc_q, pc_d;
    logic [31:0]          pc_out_q, pc_out_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic                 valid_q, valid_d;
    logic [31:0]          pc_seq;
`ifdef FETCH_BRANCH_EN
    logic [31:0]          pc_branch;
`endif

    pc_next_calc #(.PC_STEP(PC_STEP)) u_pc_next (
`ifdef FETCH_BRANCH_EN
        .branch_offset_i (BRANCH_OFFSET),
        .pc_branch_o     (pc_branch),
`endif
        .pc_i            (pc_q),
        .pc_seq_o        (pc_seq)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            pc_out_q <= '0;
            ir_q     <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc_out_q <= pc_out_d;
            ir_q     <= ir_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pc_out_d = pc_out_q;
        ir_d     = ir_q;
        valid_d  = valid_q;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (!bus.IMEM_BUSYWAIT) begin
                    ir_d     = bus.IMEM_READDATA;
                    pc_out_d = pc_q;
                    pc_d     = pc_seq;
                    valid_d  = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!bus.STALL) begin
                    valid_d = 1'b0;
                    state_d = S_FETCH;
`ifdef FETCH_BRANCH_EN
                    // pc_q already points at the next sequential instruction.
                    if (BRANCH_TAKEN) pc_d = pc_branch;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request is a function of state only; RESET gating keeps it low even
    // in the delta before the async reset reaches state_q.
    assign bus.IMEM_READ    = (state_q == S_FETCH) && !RESET;
    assign bus.IMEM_ADDRESS = pc_q;
    assign bus.INSTR_VALID  = valid_q;
    assign bus.PC_OUT       = pc_out_q;
    assign bus.OPCODE       = ir_q[OP_MSB:OP_LSB];
    assign bus.DEST         = ir_q[DEST_MSB:DEST_LSB];
    assign bus.SRC1         = ir_q[SRC1_MSB:SRC1_LSB];
    assign bus.SRC2_IMM     = ir_q[SRC2_MSB:SRC2_LSB];

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic clk = 1'b0;
    logic rst;
    logic rst2;
    always #5 clk = ~clk;

    logic [31:0] mem [64];

    instr_fetch_unit_if bus1();
    instr_fetch_unit_if bus2();

    assign bus1.IMEM_READDATA = mem[bus1.IMEM_ADDRESS[7:2]];
    assign bus2.IMEM_READDATA = mem[bus2.IMEM_ADDRESS[7:2]];

`ifdef FETCH_BRANCH_EN
    logic       bt;
    logic [7:0] bo;
`endif

    instr_fetch_unit #(.RESET_PC(32'd0), .PC_STEP(32'd4)) dut (
        .CLK           (clk),
        .RESET         (rst),
`ifdef FETCH_BRANCH_EN
        .BRANCH_TAKEN  (bt),
        .BRANCH_OFFSET (bo),
`endif
        .bus           (bus1.master)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(32'd4)) dut_wrap (
        .CLK           (clk),
        .RESET         (rst2),
`ifdef FETCH_BRANCH_EN
        .BRANCH_TAKEN  (1'b0),
        .BRANCH_OFFSET (8'h00),
`endif
        .bus           (bus2.master)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Behavioural model: "started" = left the post-reset idle cycle;
    // "valid" = an instruction is held for downstream, else a fetch is pending.
    bit          m_started, m_valid;
    logic [31:0] m_pc, m_pcout, m_ir;

    task automatic model_reset();
        m_started = 0;
        m_valid   = 0;
        m_pc      = 32'd0;
        m_pcout   = 32'd0;
        m_ir      = 32'd0;
    endtask

    task automatic model_update();
        if (!m_started) begin
            m_started = 1;
        end else if (!m_valid) begin
            if (!bus1.IMEM_BUSYWAIT) begin
                m_ir    = mem[m_pc[7:2]];
                m_pcout = m_pc;
                m_pc    = m_pc + 32'd4;
                m_valid = 1;
            end
        end else if (!bus1.STALL) begin
            m_valid = 0;
`ifdef FETCH_BRANCH_EN
            if (bt) m_pc = m_pc + 32'(int'($signed(bo)) * 4);
`endif
        end
    endtask

    task automatic compare_all();
        chk("imem_read", 32'(bus1.IMEM_READ), 32'(m_started && !m_valid));
        if (m_started && !m_valid) chk("imem_addr", bus1.IMEM_ADDRESS, m_pc);
        chk("instr_valid", 32'(bus1.INSTR_VALID), 32'(m_valid));
        chk("pc_out",   bus1.PC_OUT,          m_pcout);
        chk("opcode",   32'(bus1.OPCODE),     32'(m_ir[31:24]));
        chk("dest",     32'(bus1.DEST),       32'(m_ir[23:16]));
        chk("src1",     32'(bus1.SRC1),       32'(m_ir[15:8]));
        chk("src2_imm", 32'(bus1.SRC2_IMM),   32'(m_ir[7:0]));
    endtask

    // One clock: model advances on the edge with the inputs it saw, DUT is
    // compared on the following falling edge.
    task automatic step();
        @(posedge clk);
        if (!rst) model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic run_to(input logic [31:0] target);
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            step();
            if (m_valid && m_pcout == target) ok = 1;
        end
        chk("reach_target", 32'(ok), 32'd1);
    endtask

    initial begin
        rst  = 1'b1;
        rst2 = 1'b1;
        bus1.IMEM_BUSYWAIT = 1'b0;
        bus1.STALL         = 1'b0;
        bus2.IMEM_BUSYWAIT = 1'b0;
        bus2.STALL         = 1'b0;
`ifdef FETCH_BRANCH_EN
        bt = 1'b0;
        bo = 8'h00;
`endif
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h0102_0304;
        model_reset();

        repeat (2) @(negedge clk);
        compare_all();
        chk("reset_read",  32'(bus1.IMEM_READ), 32'd0);
        chk("reset_valid", 32'(bus1.INSTR_VALID), 32'd0);

        // First fetch from address 0, zero-wait.
        rst = 1'b0;
        step();
        chk("first_read", 32'(bus1.IMEM_READ), 32'd1);
        chk("first_addr", bus1.IMEM_ADDRESS, 32'd0);
        step();
        chk("first_valid",  32'(bus1.INSTR_VALID), 32'd1);
        chk("first_opcode", 32'(bus1.OPCODE),   32'h01);
        chk("first_dest",   32'(bus1.DEST),     32'h02);
        chk("first_src1",   32'(bus1.SRC1),     32'h03);
        chk("first_src2",   32'(bus1.SRC2_IMM), 32'h04);
        chk("first_pcout",  bus1.PC_OUT,        32'd0);
        step();
        chk("second_addr", bus1.IMEM_ADDRESS, 32'd4);
        step();
        step();

        // Busywait for 3 cycles on the fetch at 0x8.
        bus1.IMEM_BUSYWAIT = 1'b1;
        repeat (3) begin
            step();
            chk("bw_read", 32'(bus1.IMEM_READ), 32'd1);
            chk("bw_addr", bus1.IMEM_ADDRESS, 32'h8);
            chk("bw_valid", 32'(bus1.INSTR_VALID), 32'd0);
        end
        bus1.IMEM_BUSYWAIT = 1'b0;
        step();
        chk("bw_valid_rise", 32'(bus1.INSTR_VALID), 32'd1);
        chk("bw_pcout", bus1.PC_OUT, 32'h8);

        // Stall for 4 cycles in issue.
        bus1.STALL = 1'b1;
        repeat (4) begin
            step();
            chk("stall_valid",  32'(bus1.INSTR_VALID), 32'd1);
            chk("stall_read",   32'(bus1.IMEM_READ), 32'd0);
            chk("stall_pcout",  bus1.PC_OUT, 32'h8);
            chk("stall_opcode", 32'(bus1.OPCODE), 32'(mem[2][31:24]));
        end
        bus1.STALL = 1'b0;
        step();
        chk("resume_read", 32'(bus1.IMEM_READ), 32'd1);
        chk("resume_addr", bus1.IMEM_ADDRESS, 32'hC);
        step();
        step();

        // Reset while the fetch at 0x10 is blocked.
        bus1.IMEM_BUSYWAIT = 1'b1;
        step();
        chk("pre_rst_addr", bus1.IMEM_ADDRESS, 32'h10);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_drop_read", 32'(bus1.IMEM_READ), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus1.IMEM_BUSYWAIT = 1'b0;
        step();
        chk("post_rst_read", 32'(bus1.IMEM_READ), 32'd1);
        chk("post_rst_addr", bus1.IMEM_ADDRESS, 32'd0);

`ifdef FETCH_BRANCH_EN
        // Backward branch of -2 words from PC_OUT=0x20.
        run_to(32'h20);
        bt = 1'b1;
        bo = 8'hFE;
        step();
        chk("br_back_addr", bus1.IMEM_ADDRESS, 32'h1C);
        bt = 1'b0;
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        // Forward branch of +3 words from PC_OUT=0x20.
        run_to(32'h20);
        bt = 1'b1;
        bo = 8'h03;
        step();
        chk("br_fwd_addr", bus1.IMEM_ADDRESS, 32'h30);
        bt = 1'b0;
`endif

        // Randomized phase with occasional resets.
        repeat (3000) begin
            bus1.IMEM_BUSYWAIT = ($urandom_range(0, 2) == 0);
            bus1.STALL         = ($urandom_range(0, 2) == 0);
`ifdef FETCH_BRANCH_EN
            bt = ($urandom_range(0, 3) == 0);
            bo = 8'($urandom);
`endif
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                model_reset();
                step();
                rst = 1'b0;
            end else begin
                step();
            end
        end

        // PC wrap on the second instance; primary instance parked in reset.
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst2 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("wrap_read", 32'(bus2.IMEM_READ), 32'd1);
        chk("wrap_addr", bus2.IMEM_ADDRESS, 32'hFFFF_FFFC);
        @(posedge clk);
        @(negedge clk);
        chk("wrap_valid",  32'(bus2.INSTR_VALID), 32'd1);
        chk("wrap_pcout",  bus2.PC_OUT, 32'hFFFF_FFFC);
        chk("wrap_opcode", 32'(bus2.OPCODE), 32'(mem[63][31:24]));
        @(posedge clk);
        @(negedge clk);
        chk("wrap_next_read", 32'(bus2.IMEM_READ), 32'd1);
        chk("wrap_next_addr", bus2.IMEM_ADDRESS, 32'h0);
        rst2 = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
